// File: rtl/router_in_port_if.sv
// Link bundle between a node endpoint / switch allocator and a router input port.
// The node and allocator drive put/payload/grant; the port drives the rest.
interface router_in_port_if #(
  parameter int NPORTS = 4
);
  logic              put;
  logic [7:0]        payload;
  logic              free;
  logic [31:0]       out_pkt;
  logic              out_valid;
  logic [NPORTS-1:0] out_req;
  logic              grant;
  logic              err;

  modport master (
    output put, payload, grant,
    input  free, out_pkt, out_valid, out_req, err
  );

  modport slave (
    input  put, payload, grant,
    output free, out_pkt, out_valid, out_req, err
  );
endinterface

// File: rtl/router_in_port.sv
// Router input port: byte-serial receive, 32-bit packet FIFO, route decode.
// Optional ROUTER_IN_PKT_COUNT_EN adds a 16-bit completed-packet counter.
module router_in_port #(
  parameter int          DEPTH     = 4,
  parameter int          NPORTS    = 4,
  parameter logic [31:0] ROUTE_MAP = 32'h0000_0000
) (
  input logic clk,
  input logic rst_b,
  router_in_port_if.slave link
`ifdef ROUTER_IN_PKT_COUNT_EN
  ,
  output logic [15:0] pkt_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, RECV} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          free_q, free_d;
  logic          err_q, err_d;
  logic          wr, pop;
  logic          proto_err, map_err;
  logic [31:0]   wdata;
  logic [31:0]   head;
  logic [1:0]    port_idx;
  logic [31:0]   mem_q [DEPTH];

  // Receive FSM: assemble four bytes, flag protocol violations.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr        = 1'b0;
    proto_err = 1'b0;
    wdata     = {shift_q, link.payload};
    unique case (state_q)
      IDLE: begin
        if (link.put) begin
          if (free_q) begin
            shift_d = {16'h0, link.payload};
            cnt_d   = 2'd1;
            state_d = RECV;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      RECV: begin
        if (!link.put) begin
          proto_err = 1'b1;
          cnt_d     = 2'd0;
          state_d   = IDLE;
        end else begin
          shift_d = {shift_q[15:0], link.payload};
          if (cnt_q == 2'd3) begin
            wr      = 1'b1;
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer bookkeeping; free only when idle with a slot left after this edge.
  always_comb begin
    pop    = link.grant && link.out_valid;
    wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    occ_d  = occ_q;
    if (wr && !pop)
      occ_d = occ_q + ONE;
    else if (!wr && pop)
      occ_d = occ_q - ONE;
    free_d = (state_d == IDLE) && (occ_d < FULL);
  end

  // Head packet presentation and output-port request decode.
  always_comb begin
    link.out_valid = (occ_q != '0);
    head           = mem_q[rptr_q];
    link.out_pkt   = link.out_valid ? head : 32'h0;
    port_idx       = ROUTE_MAP[{link.out_pkt[27:24], 1'b0} +: 2];
    map_err        = link.out_valid && (int'(port_idx) >= NPORTS);
    for (int p = 0; p < NPORTS; p++)
      link.out_req[p] = link.out_valid && (int'(port_idx) == p);
    link.free      = free_q;
    link.err       = err_q;
    err_d          = err_q | proto_err | map_err;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 24'h0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      free_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
      err_q   <= err_d;
    end
  end

  // Packet storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wptr_q] <= wdata;
  end

`ifdef ROUTER_IN_PKT_COUNT_EN
  logic [15:0] pkt_count_q;

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      pkt_count_q <= 16'h0;
    else if (wr)
      pkt_count_q <= pkt_count_q + 16'h1;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_router_in_port.sv
// Directed self-checking bench for router_in_port.
// Dest 3 routes to port 3, every other dest to port 0.
module tb_router_in_port;
  logic clk;
  logic rst_b;
  int   errors;
  int   checks;
  logic [31:0] q[$];

`ifdef ROUTER_IN_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif

  router_in_port_if #(.NPORTS(4)) link ();

  router_in_port #(
    .DEPTH    (4),
    .NPORTS   (4),
    .ROUTE_MAP(32'h0000_00C0)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .link (link)
`ifdef ROUTER_IN_PKT_COUNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b        = 1'b0;
    link.put     = 1'b0;
    link.payload = 8'h00;
    link.grant   = 1'b0;
    repeat (2) cyc();
    rst_b = 1'b1;
    cyc();
  endtask

  task automatic send_pkt(input logic [31:0] p, input logic grant_last);
    for (int i = 0; i < 4; i++) begin
      link.put     = 1'b1;
      link.payload = p[31-8*i -: 8];
      link.grant   = (i == 3) && grant_last;
      cyc();
    end
    link.put   = 1'b0;
    link.grant = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (link.free !== 1'b1) begin
      errors++; $display("FAIL reset_free got=%b exp=1", link.free);
    end
    checks++;
    if (link.out_valid !== 1'b0 || link.out_req !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out got=%b/%b exp=0/0000", link.out_valid, link.out_req);
    end
    checks++;
    if (link.out_pkt !== 32'h0 || link.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pkt_err got=%h/%b exp=0/0", link.out_pkt, link.err);
    end
  endtask

  task automatic test_single();
    logic [31:0] p;
    logic [7:0]  fr;
    do_reset();
    p  = 32'h13ABCDEF;
    fr = '0;
    for (int i = 0; i < 4; i++) begin
      link.put     = 1'b1;
      link.payload = p[31-8*i -: 8];
      if (i > 0) fr[i] = link.free;
      cyc();
    end
    link.put = 1'b0;
    checks++;
    if (fr[3:1] !== 3'b000) begin
      errors++; $display("FAIL single_free_busy got=%b exp=000", fr[3:1]);
    end
    checks++;
    if (link.out_valid !== 1'b1 || link.out_pkt !== 32'h13ABCDEF) begin
      errors++;
      $display("FAIL single_pkt got=%b/%h exp=1/13abcdef", link.out_valid, link.out_pkt);
    end
    checks++;
    if (link.out_req !== 4'b1000 || link.free !== 1'b1) begin
      errors++;
      $display("FAIL single_req_free got=%b/%b exp=1000/1", link.out_req, link.free);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    send_pkt(32'h1A000001, 1'b0);
    send_pkt(32'h23000002, 1'b0);
    send_pkt(32'h35000003, 1'b0);
    send_pkt(32'h46000004, 1'b0);
    checks++;
    if (link.free !== 1'b0 || link.out_pkt !== 32'h1A000001) begin
      errors++;
      $display("FAIL full_state got=%b/%h exp=0/1a000001", link.free, link.out_pkt);
    end
    checks++;
    if (link.out_req !== 4'b0001) begin
      errors++; $display("FAIL full_req got=%b exp=0001", link.out_req);
    end
    link.grant = 1'b1;
    cyc();
    link.grant = 1'b0;
    checks++;
    if (link.free !== 1'b1 || link.out_pkt !== 32'h23000002) begin
      errors++;
      $display("FAIL pop_state got=%b/%h exp=1/23000002", link.free, link.out_pkt);
    end
    checks++;
    if (link.out_req !== 4'b1000) begin
      errors++; $display("FAIL pop_req got=%b exp=1000", link.out_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    do_reset();
    q.delete();
    for (int i = 0; i < 10; i++) begin
      p = 32'hC0DE_0000 + i * 32'h0101_0011;
      send_pkt(p, i >= 2);
      if (i >= 2) void'(q.pop_front());
      q.push_back(p);
      checks++;
      if (link.out_pkt !== q[0] || link.free !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got=%h/%b exp=%h/1", i, link.out_pkt, link.free, q[0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (link.out_valid !== 1'b1 || link.out_pkt !== q[0]) begin
        errors++;
        $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, link.out_valid, link.out_pkt, q[0]);
      end
      link.grant = 1'b1;
      cyc();
      link.grant = 1'b0;
      void'(q.pop_front());
    end
    checks++;
    if (link.out_valid !== 1'b0 || link.err !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got=%b/%b exp=0/0", link.out_valid, link.err);
    end
  endtask

  task automatic test_gap();
    do_reset();
    link.put = 1'b1; link.payload = 8'h11; cyc();
    link.payload = 8'h22; cyc();
    link.put = 1'b0; cyc();
    checks++;
    if (link.err !== 1'b1 || link.out_valid !== 1'b0 || link.free !== 1'b1) begin
      errors++;
      $display("FAIL gap_err got=%b/%b/%b exp=1/0/1", link.err, link.out_valid, link.free);
    end
    send_pkt(32'h01020304, 1'b0);
    checks++;
    if (link.out_pkt !== 32'h01020304 || link.out_req !== 4'b0001) begin
      errors++;
      $display("FAIL gap_next got=%h/%b exp=01020304/0001", link.out_pkt, link.out_req);
    end
    link.grant = 1'b1; cyc(); link.grant = 1'b0;
    checks++;
    if (link.out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_single got=%b exp=0", link.out_valid);
    end
  endtask

  task automatic test_put_full();
    logic [31:0] exp [4];
    do_reset();
    exp[0] = 32'h31000011; exp[1] = 32'h42000022;
    exp[2] = 32'h53000033; exp[3] = 32'h64000044;
    for (int i = 0; i < 4; i++) send_pkt(exp[i], 1'b0);
    checks++;
    if (link.err !== 1'b0 || link.free !== 1'b0) begin
      errors++; $display("FAIL full_pre got=%b/%b exp=0/0", link.err, link.free);
    end
    link.put = 1'b1; link.payload = 8'hFF; cyc();
    link.put = 1'b0; cyc();
    checks++;
    if (link.err !== 1'b1 || link.free !== 1'b0) begin
      errors++; $display("FAIL full_put got=%b/%b exp=1/0", link.err, link.free);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (link.out_valid !== 1'b1 || link.out_pkt !== exp[i]) begin
        errors++;
        $display("FAIL full_keep_%0d got=%b/%h exp=1/%h", i, link.out_valid, link.out_pkt, exp[i]);
      end
      link.grant = 1'b1; cyc(); link.grant = 1'b0;
    end
    checks++;
    if (link.out_valid !== 1'b0 || link.err !== 1'b1) begin
      errors++;
      $display("FAIL full_drain got=%b/%b exp=0/1", link.out_valid, link.err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    link.put = 1'b1; link.payload = 8'hEE; cyc();
    link.put = 1'b0; cyc();
    send_pkt(32'h7700AA55, 1'b0);
    link.put = 1'b1; link.payload = 8'h99; cyc();
    link.payload = 8'h88; cyc();
    link.put = 1'b0;
    rst_b = 1'b0;
    #2;
    checks++;
    if (link.out_valid !== 1'b0 || link.free !== 1'b1 || link.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b/%b/%b exp=0/1/0", link.out_valid, link.free, link.err);
    end
    cyc();
    rst_b = 1'b1;
    cyc();
    send_pkt(32'h23456789, 1'b0);
    checks++;
    if (link.out_pkt !== 32'h23456789 || link.out_req !== 4'b1000) begin
      errors++;
      $display("FAIL mid_next got=%h/%b exp=23456789/1000", link.out_pkt, link.out_req);
    end
`ifdef ROUTER_IN_PKT_COUNT_EN
    checks++;
    if (pkt_count !== 16'd1) begin
      errors++; $display("FAIL pkt_count got=%0d exp=1", pkt_count);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_b  = 1'b0;
    link.put     = 1'b0;
    link.payload = 8'h00;
    link.grant   = 1'b0;
    test_reset();
    test_single();
    test_full_pop();
    test_back_to_back();
    test_gap();
    test_put_full();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
